// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the multi-port register file
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width
//   ZERO_ADDR                       : index of the hard-wired zero register
//   reg_addr_t / reg_data_t         : default-width address and data types
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int ZERO_ADDR      = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - decoder/ALU side bus of the multi-port register file
// Signals:
//   rd_en, ra_addr, rb_addr            : read request for both ports
//   ra_data, rb_data, rd_valid         : registered read results (latency 1)
//   stall, busy_a, busy_b              : combinational scoreboard status
//   wr_en, wr_addr, wr_data            : write-back from the ALU
//   rsv_en, rsv_addr                   : reservation of a pending write
// Modports: master (decoder/ALU side), slave (register file side)
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              rd_valid;
  logic              stall;
  logic              busy_a;
  logic              busy_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  modport master (
    output rd_en, ra_addr, rb_addr,
    output wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr,
    input  ra_data, rb_data, rd_valid,
    input  stall, busy_a, busy_b
  );

  modport slave (
    input  rd_en, ra_addr, rb_addr,
    input  wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr,
    output ra_data, rb_data, rd_valid,
    output stall, busy_a, busy_b
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for pending writes
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   rd_en_i                 : read request (qualifies stall_o)
//   ra_addr_i, rb_addr_i    : read addresses whose busy bits are reported
//   wr_en_i, wr_addr_i      : write-back, clears the busy bit of wr_addr_i
//   rsv_en_i, rsv_addr_i    : reservation, sets the busy bit of rsv_addr_i
//   busy_a_o, busy_b_o      : busy bits of the read addresses (combinational)
//   stall_o                 : read request blocked this cycle (combinational)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              stall_o
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA       = ADDR_W'(ZERO_ADDR);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr_ok;
  logic                rsv_ok;

  assign wr_ok  = wr_en_i  && !(ZERO_REG && (wr_addr_i  == ZA));
  assign rsv_ok = rsv_en_i && !(ZERO_REG && (rsv_addr_i == ZA));

  // Release first, then reserve: a same-edge reservation of the address
  // being written leaves the bit set for the next producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A write landing this cycle already satisfies the dependency. Bit 0 is
  // never set when the zero register is enabled, so it always reads clear.
  assign busy_a_o = busy_q[ra_addr_i] & ~(wr_en_i & (wr_addr_i == ra_addr_i));
  assign busy_b_o = busy_q[rb_addr_i] & ~(wr_en_i & (wr_addr_i == rb_addr_i));
  assign stall_o  = rd_en_i & (busy_a_o | busy_b_o);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2-read/1-write register file with busy scoreboard
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-low reset
//   bus  : regfile_mp_if.slave (read, write-back, reservation, status)
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to an
//   accepted read of the written address; without it the read sees the
//   old contents.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA       = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] ra_q;
  logic [DATA_W-1:0] ra_d;
  logic [DATA_W-1:0] rb_q;
  logic [DATA_W-1:0] rb_d;
  logic              rd_valid_q;
  logic              rd_valid_d;
  logic              stall;
  logic              accept;
  logic              wr_ok;
  logic              ra_hit;
  logic              rb_hit;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (bus.rd_en),
    .ra_addr_i  (bus.ra_addr),
    .rb_addr_i  (bus.rb_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .busy_a_o   (bus.busy_a),
    .busy_b_o   (bus.busy_b),
    .stall_o    (stall)
  );

  assign bus.stall = stall;
  assign accept    = bus.rd_en & ~stall;
  assign wr_ok     = bus.wr_en && !(ZERO_REG && (bus.wr_addr == ZA));

`ifdef REGFILE_BYPASS_EN
  assign ra_hit = wr_ok & (bus.wr_addr == bus.ra_addr);
  assign rb_hit = wr_ok & (bus.wr_addr == bus.rb_addr);
`else
  assign ra_hit = 1'b0;
  assign rb_hit = 1'b0;
`endif

  // Unaccepted reads hold the previous operands; only rd_valid drops.
  always_comb begin
    ra_d       = ra_q;
    rb_d       = rb_q;
    rd_valid_d = 1'b0;
    if (accept) begin
      ra_d       = ra_hit ? bus.wr_data : mem_q[bus.ra_addr];
      rb_d       = rb_hit ? bus.wr_data : mem_q[bus.rb_addr];
      rd_valid_d = 1'b1;
      if (ZERO_REG && (bus.ra_addr == ZA)) begin
        ra_d = '0;
      end
      if (ZERO_REG && (bus.rb_addr == ZA)) begin
        rb_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      ra_q       <= '0;
      rb_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.ra_data  = ra_q;
  assign bus.rb_data  = rb_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (zero-reg and plain builds side by side)
module tb_regfile_mp;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rd_en, wr_en, rsv_en;
  logic [2:0] ra, rb, wa, rsa;
  logic [7:0] wd;

  regfile_mp_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  regfile_mp_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  assign bus0.rd_en = rd_en;  assign bus1.rd_en = rd_en;
  assign bus0.ra_addr = ra;   assign bus1.ra_addr = ra;
  assign bus0.rb_addr = rb;   assign bus1.rb_addr = rb;
  assign bus0.wr_en = wr_en;  assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wa;   assign bus1.wr_addr = wa;
  assign bus0.wr_data = wd;   assign bus1.wr_data = wd;
  assign bus0.rsv_en = rsv_en; assign bus1.rsv_en = rsv_en;
  assign bus0.rsv_addr = rsa; assign bus1.rsv_addr = rsa;

  regfile_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  regfile_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: instance 0 has the zero register, instance 1 does not.
  logic [7:0] m_mem  [2][8];
  bit         m_busy [2][8];
  logic [7:0] m_ra [2];
  logic [7:0] m_rb [2];
  bit         m_valid [2];

  function automatic bit ok(input int k, input int a);
    return !(k == 0 && a == 0);
  endfunction

  function automatic bit m_busy_eff(input int k, input int a);
    return ok(k, a) && m_busy[k][a] && !(wr_en && int'(wa) == a);
  endfunction

  function automatic bit m_stall(input int k);
    return rd_en && (m_busy_eff(k, int'(ra)) || m_busy_eff(k, int'(rb)));
  endfunction

  function automatic logic [7:0] m_read(input int k, input int a);
    if (!ok(k, a)) return 8'h00;
    if (BYP && wr_en && int'(wa) == a && ok(k, a)) return wd;
    return m_mem[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) begin
        m_mem[k][a]  = 8'h00;
        m_busy[k][a] = 1'b0;
      end
      m_ra[k] = 8'h00; m_rb[k] = 8'h00; m_valid[k] = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input int a, input int b, input bit we, input int w,
                       input int d, input bit rs, input int s, input bit rstv);
    rd_en = r; ra = 3'(a); rb = 3'(b); wr_en = we; wa = 3'(w); wd = 8'(d);
    rsv_en = rs; rsa = 3'(s); rst = rstv;
  endtask

  task automatic comb_phase();
    #1;
    check("stall0",  32'(bus0.stall),  32'(m_stall(0)));
    check("stall1",  32'(bus1.stall),  32'(m_stall(1)));
    check("busy_a0", 32'(bus0.busy_a), 32'(m_busy_eff(0, int'(ra))));
    check("busy_b0", 32'(bus0.busy_b), 32'(m_busy_eff(0, int'(rb))));
    check("busy_a1", 32'(bus1.busy_a), 32'(m_busy_eff(1, int'(ra))));
    check("busy_b1", 32'(bus1.busy_b), 32'(m_busy_eff(1, int'(rb))));
  endtask

  task automatic edge_phase();
    bit acc;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int a = 0; a < 8; a++) begin
          m_mem[k][a] = 8'h00; m_busy[k][a] = 1'b0;
        end
        m_ra[k] = 8'h00; m_rb[k] = 8'h00; m_valid[k] = 1'b0;
      end else begin
        acc = rd_en && !m_stall(k);
        if (acc) begin
          m_ra[k] = m_read(k, int'(ra));
          m_rb[k] = m_read(k, int'(rb));
        end
        m_valid[k] = acc;
        if (wr_en && ok(k, int'(wa))) begin
          m_mem[k][wa]  = wd;
          m_busy[k][wa] = 1'b0;
        end
        if (rsv_en && ok(k, int'(rsa))) m_busy[k][rsa] = 1'b1;
      end
    end
    #1;
    check("ra_data0",  32'(bus0.ra_data),  32'(m_ra[0]));
    check("rb_data0",  32'(bus0.rb_data),  32'(m_rb[0]));
    check("rd_valid0", 32'(bus0.rd_valid), 32'(m_valid[0]));
    check("ra_data1",  32'(bus1.ra_data),  32'(m_ra[1]));
    check("rb_data1",  32'(bus1.rb_data),  32'(m_rb[1]));
    check("rd_valid1", 32'(bus1.rd_valid), 32'(m_valid[1]));
  endtask

  task automatic cycle();
    comb_phase();
    edge_phase();
    @(negedge clk);
  endtask

  typedef struct {
    bit rd; int ra; int rb; bit we; int wa; int wd; bit rs; int rsa;
    bit e_stall; logic [7:0] e_ra0; logic [7:0] e_rb0; bit e_valid; logic [7:0] e_ra1;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] byp_v;
    byp_v = BYP ? 8'h22 : 8'h11;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Directed table: r3 write/read, r0 zero-reg behaviour, same-edge rsv+wr on r2.
    tbl[0] = '{0, 0, 0, 1, 3, 'hA5, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[1] = '{1, 3, 0, 0, 0, 0,    0, 0, 0, 8'hA5, 8'h00, 1, 8'hA5};
    tbl[2] = '{0, 0, 0, 1, 0, 'hFF, 0, 0, 0, 8'hA5, 8'h00, 0, 8'hA5};
    tbl[3] = '{1, 0, 3, 0, 0, 0,    0, 0, 0, 8'h00, 8'hA5, 1, 8'hFF};
    tbl[4] = '{0, 0, 0, 1, 2, 'h11, 1, 2, 0, 8'h00, 8'hA5, 0, 8'hFF};
    tbl[5] = '{1, 2, 3, 0, 0, 0,    0, 0, 1, 8'h00, 8'hA5, 0, 8'hFF};
    tbl[6] = '{1, 2, 2, 1, 2, 'h22, 0, 0, 0, byp_v, byp_v, 1, byp_v};

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].rs, tbl[i].rsa, 1'b1);
      comb_phase();
      check($sformatf("tbl%0d_stall0", i), 32'(bus0.stall), 32'(tbl[i].e_stall));
      check($sformatf("tbl%0d_stall1", i), 32'(bus1.stall), 32'(tbl[i].e_stall));
      edge_phase();
      check($sformatf("tbl%0d_ra0", i),   32'(bus0.ra_data),  32'(tbl[i].e_ra0));
      check($sformatf("tbl%0d_rb0", i),   32'(bus0.rb_data),  32'(tbl[i].e_rb0));
      check($sformatf("tbl%0d_valid", i), 32'(bus0.rd_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_ra1", i),   32'(bus1.ra_data),  32'(tbl[i].e_ra1));
      @(negedge clk);
    end

    // Reserved r5 stalls, then a same-cycle write releases it.
    drive(0, 0, 0, 1, 5, 'h77, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 1);    cycle();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1);
    comb_phase();
    check("t4_stall", 32'(bus0.stall), 32'h1);
    edge_phase();
    check("t4_valid_low", 32'(bus0.rd_valid), 32'h0);
    check("t4_ra_held",   32'(bus0.ra_data),  32'(byp_v));
    @(negedge clk);
    drive(1, 5, 0, 1, 5, 'h3C, 0, 0, 1);
    comb_phase();
    check("t4_release", 32'(bus0.stall), 32'h0);
    edge_phase();
    check("t4_ra_rdw", 32'(bus0.ra_data), BYP ? 32'h3C : 32'h77);
    @(negedge clk);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 2) == 0, $urandom % 8, $urandom % 8, ($urandom % 2) == 0,
            $urandom % 8, $urandom % 256, ($urandom % 10) < 3, $urandom % 8,
            ($urandom % 64) != 0);
      cycle();
    end

    // Reset held two cycles after random traffic.
    for (int i = 0; i < 2; i++) begin
      drive(1, $urandom % 8, $urandom % 8, 1, $urandom % 8, $urandom % 256, 1,
            $urandom % 8, 0);
      cycle();
    end
    check("rst_ra",    32'(bus0.ra_data),  32'h0);
    check("rst_rb",    32'(bus0.rb_data),  32'h0);
    check("rst_valid", 32'(bus0.rd_valid), 32'h0);
    drive(0, 5, 2, 0, 0, 0, 0, 0, 1);
    #1;
    check("rst_busy_a", 32'(bus0.busy_a), 32'h0);
    check("rst_busy_b", 32'(bus1.busy_b), 32'h0);
    @(negedge clk);

    // A read accepted on a reset edge is dropped; every register reads 0.
    drive(0, 0, 0, 1, 1, 'h5A, 0, 0, 1); cycle();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);    cycle();
    check("t6_valid", 32'(bus0.rd_valid), 32'h0);
    check("t6_ra",    32'(bus0.ra_data),  32'h0);
    for (int a = 1; a < 8; a++) begin
      drive(1, a, a, 0, 0, 0, 0, 0, 1);
      cycle();
      check($sformatf("t6_r%0d_a", a), 32'(bus0.ra_data), 32'h0);
      check($sformatf("t6_r%0d_b", a), 32'(bus1.rb_data), 32'h0);
      check($sformatf("t6_r%0d_v", a), 32'(bus0.rd_valid), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
